// File: rtl/spi_slave_param_if.sv
// Bus bundle for spi_slave_param: SPI pins plus the RAM-side rx/tx handshake.
// The err member and its modport entries exist only when SPI_SLV_ERR_EN is defined.
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic              busy;
`ifdef SPI_SLV_ERR_EN
    logic              err;
`endif

    modport slave (
`ifdef SPI_SLV_ERR_EN
        output err,
`endif
        input  SS_n, MOSI, tx_data, tx_valid,
        output rx_data, rx_valid, MISO, busy
    );

    modport master (
`ifdef SPI_SLV_ERR_EN
        input  err,
`endif
        output SS_n, MOSI, tx_data, tx_valid,
        input  rx_data, rx_valid, MISO, busy
    );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: {cmd, payload} frames in on MOSI, RAM read data out on MISO.
// Optional SPI_SLV_ERR_EN adds a one-cycle err pulse on abort or read-data-without-address.
module spi_slave_param #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_param_if.slave  bus
);
    localparam int CW = $clog2(DATA_W + 3);

    typedef enum logic [2:0] {IDLE, RX, TX_WAIT, TX, DONE} state_t;

    state_t            cs, ns;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W:0]   rx_shift, rx_shift_nxt;
    logic [DATA_W-2:0] tx_shift, tx_shift_nxt;
    logic [DATA_W+1:0] rx_data_q, rx_data_nxt, word;
    logic [1:0]        cmd;
    logic              rx_valid_q, rx_valid_nxt;
    logic              miso_q, miso_nxt;
    logic              pend_q, pend_nxt;
`ifdef SPI_SLV_ERR_EN
    logic              err_q, err_nxt;
`endif

    assign word = {rx_shift, bus.MOSI};
    assign cmd  = word[DATA_W+1 -: 2];

    always_comb begin
        ns           = cs;
        cnt_nxt      = cnt;
        rx_shift_nxt = rx_shift;
        tx_shift_nxt = tx_shift;
        rx_data_nxt  = rx_data_q;
        rx_valid_nxt = 1'b0;
        miso_nxt     = miso_q;
        pend_nxt     = pend_q;
`ifdef SPI_SLV_ERR_EN
        err_nxt      = 1'b0;
`endif
        case (cs)
            IDLE: begin
                miso_nxt = 1'b0;
                if (!bus.SS_n) begin
                    ns      = RX;
                    cnt_nxt = CW'(DATA_W + 2);
                end
            end
            RX: begin
                if (bus.SS_n) begin
                    ns       = IDLE;
                    miso_nxt = 1'b0;
`ifdef SPI_SLV_ERR_EN
                    err_nxt  = 1'b1;
`endif
                end else begin
                    rx_shift_nxt = word[DATA_W:0];
                    cnt_nxt      = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        ns = DONE;
                        if (cmd != 2'b11 || pend_q) begin
                            rx_data_nxt  = word;
                            rx_valid_nxt = 1'b1;
                        end
                        if (cmd == 2'b10)
                            pend_nxt = 1'b1;
                        if (cmd == 2'b11 && pend_q)
                            ns = TX_WAIT;
`ifdef SPI_SLV_ERR_EN
                        if (cmd == 2'b11 && !pend_q)
                            err_nxt = 1'b1;
`endif
                    end
                end
            end
            TX_WAIT: begin
                if (bus.SS_n) begin
                    ns       = IDLE;
                    miso_nxt = 1'b0;
`ifdef SPI_SLV_ERR_EN
                    err_nxt  = 1'b1;
`endif
                end else if (bus.tx_valid) begin
                    // MSB goes straight to MISO; only the remaining bits are kept for shifting
                    miso_nxt     = bus.tx_data[DATA_W-1];
                    tx_shift_nxt = bus.tx_data[DATA_W-2:0];
                    cnt_nxt      = CW'(DATA_W - 1);
                    ns           = TX;
                end
            end
            TX: begin
                if (bus.SS_n) begin
                    ns       = IDLE;
                    miso_nxt = 1'b0;
                    pend_nxt = 1'b0;
`ifdef SPI_SLV_ERR_EN
                    err_nxt  = 1'b1;
`endif
                end else if (cnt != '0) begin
                    miso_nxt     = tx_shift[DATA_W-2];
                    tx_shift_nxt = {tx_shift[DATA_W-3:0], 1'b0};
                    cnt_nxt      = cnt - CW'(1);
                end else begin
                    pend_nxt = 1'b0;
                    ns       = DONE;
                end
            end
            DONE: begin
                miso_nxt = 1'b0;
                if (bus.SS_n)
                    ns = IDLE;
            end
            default: ns = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs         <= IDLE;
            cnt        <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            pend_q     <= 1'b0;
`ifdef SPI_SLV_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            cs         <= ns;
            cnt        <= cnt_nxt;
            rx_shift   <= rx_shift_nxt;
            tx_shift   <= tx_shift_nxt;
            rx_data_q  <= rx_data_nxt;
            rx_valid_q <= rx_valid_nxt;
            miso_q     <= miso_nxt;
            pend_q     <= pend_nxt;
`ifdef SPI_SLV_ERR_EN
            err_q      <= err_nxt;
`endif
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.MISO     = miso_q;
    assign bus.busy     = (cs != IDLE);
`ifdef SPI_SLV_ERR_EN
    assign bus.err      = err_q;
`endif
endmodule
